// File: rtl/bist_pkg.sv
// Shared BIST definitions: ORA state encoding and default MISR/PRPG constants.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } ora_state_t;

    // Feedback taps: bit i set means the MSB feeds stage i (bit 0 always set).
    localparam logic [3:0]  POLY_W4  = 4'b0011;           // x^4+x+1
    localparam logic [3:0]  SEED_W4  = 4'b0000;
    localparam logic [7:0]  POLY_W8  = 8'h1D;             // x^8+x^4+x^3+x^2+1
    localparam logic [7:0]  SEED_W8  = 8'h00;
    localparam logic [15:0] POLY_W16 = 16'h002D;          // x^16+x^5+x^3+x^2+1
    localparam logic [15:0] SEED_W16 = 16'h0000;

endpackage

// File: rtl/misr_core.sv
// Multiple-input signature register: state register plus XOR feedback network.
module misr_core
    import bist_pkg::*;
#(
    parameter int unsigned      WIDTH = 4,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(POLY_W4)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sig
);

    logic [WIDTH-1:0] sig_next;

    // Shift up one stage, fold the MSB back through the taps, mix in the response.
    always_comb begin
        sig_next    = '0;
        sig_next[0] = (POLY[0] & sig[WIDTH-1]) ^ din[0];
        for (int i = 1; i < int'(WIDTH); i++) begin
            sig_next[i] = sig[i-1] ^ (POLY[i] & sig[WIDTH-1]) ^ din[i];
        end
    end

    // Load has priority over compaction; otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (load) begin
            sig <= load_val;
        end else if (en) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/bist_misr_analyzer.sv
// BIST output response analyzer: compacts PATTERNS responses into a MISR and
// compares the final signature against a golden value.
module bist_misr_analyzer
    import bist_pkg::*;
#(
    parameter int unsigned      WIDTH    = 4,
    parameter logic [WIDTH-1:0] POLY     = WIDTH'(POLY_W4),
    parameter logic [WIDTH-1:0] SEED     = WIDTH'(SEED_W4),
    parameter int unsigned      PATTERNS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] resp,
    input  logic             resp_valid,
    output logic             resp_ready,
    input  logic [WIDTH-1:0] golden,
    output logic [WIDTH-1:0] signature,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    localparam int unsigned CW = $clog2(PATTERNS + 1);

    ora_state_t    state_q;
    logic [CW-1:0] count_q;
    logic          start_ok;
    logic          accept;
    logic          last;

    // Start only counts when not busy; resp_ready is high only in RUN.
    always_comb begin
        start_ok = start & ((state_q == IDLE) | (state_q == DONE));
        accept   = resp_valid & resp_ready;
        last     = accept & (count_q == CW'(PATTERNS - 1));
    end

    misr_core #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_misr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (start_ok),
        .load_val (SEED),
        .en       (accept),
        .din      (resp),
        .sig      (signature)
    );

    // Run-control FSM with pattern counter and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            busy       <= 1'b0;
            resp_ready <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q    <= RUN;
                        count_q    <= '0;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        busy       <= 1'b1;
                        resp_ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept) begin
                        count_q <= count_q + CW'(1);
                    end
                    if (last) begin
                        state_q    <= COMPARE;
                        resp_ready <= 1'b0;
                    end
                end
                COMPARE: begin
                    // Signature is frozen here, so golden is checked against the final value.
                    pass    <= (signature == golden);
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
